// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified code/data SRAM between the
// instruction-fetch port and the load/store port. Data accesses have priority;
// fetch gains priority after MAX_WAIT consecutive denied cycles. Read data is
// routed back to its requester through a READ_LATENCY-deep tag pipeline.
// Optional build macro: MEM_ARB_PERF_EN enables the conflict_count counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_WAIT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instruction_enable,
    input  logic [31:0]       instruction_address,
    output logic              instr_grant,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    input  logic [3:0]        byte_enables,
    output logic              data_grant,
    output logic [31:0]       read_data,
    output logic              result_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       conflict_count
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic                    data_req;
    logic                    fetch_wins;
    logic                    read_grant;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_ins_q, tag_ins_d;
    logic [31:0]             instr_q, instr_d;
    logic [31:0]             read_data_q, read_data_d;

    // Address bits below the word offset and above the memory size are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instruction_address[31:ADDR_W+2], instruction_address[1:0],
                                address[31:ADDR_W+2], address[1:0]};

    // Per-cycle arbitration and memory-port drive from the granted requester.
    always_comb begin
        data_req    = read_enable | write_enable;
        fetch_wins  = instruction_enable && (!data_req || (wait_cnt_q >= WAIT_LIM));
        instr_grant = !rst && fetch_wins;
        data_grant  = !rst && data_req && !fetch_wins;
        read_grant  = instr_grant || (data_grant && !write_enable);
        mem_en      = instr_grant || data_grant;
        mem_we      = data_grant && write_enable;
        mem_addr    = '0;
        mem_be      = '0;
        mem_wdata   = '0;
        if (instr_grant) begin
            mem_addr = instruction_address[ADDR_W+1:2];
            mem_be   = 4'hF;
        end else if (data_grant) begin
            mem_addr = address[ADDR_W+1:2];
            if (write_enable) begin
                mem_be    = byte_enables;
                mem_wdata = write_data;
            end else begin
                mem_be = 4'hF;
            end
        end
    end

    // Fetch starvation counter: counts consecutive denied fetch cycles, saturating.
    always_comb begin
        wait_cnt_d = '0;
        if (instruction_enable && !instr_grant) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_LIM) ? WAIT_LIM : wait_cnt_q + WAIT_W'(1);
        end
    end

    // Tag pipeline shift: stage 0 captures each read grant and its originating port.
    always_comb begin
        tag_vld_d    = '0;
        tag_ins_d    = '0;
        tag_vld_d[0] = read_grant;
        tag_ins_d[0] = instr_grant;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ins_d[i] = tag_ins_q[i-1];
        end
    end

    // Response routing; returned data bypasses the holding register so it is
    // visible in the same cycle as its valid pulse, then holds until the next return.
    always_comb begin
        instr_valid  = tag_vld_q[READ_LATENCY-1] && tag_ins_q[READ_LATENCY-1];
        result_valid = tag_vld_q[READ_LATENCY-1] && !tag_ins_q[READ_LATENCY-1];
        instr        = instr_valid ? mem_rdata : instr_q;
        read_data    = result_valid ? mem_rdata : read_data_q;
        instr_d      = instr;
        read_data_d  = read_data;
    end

    // State registers; reset drops any in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            tag_vld_q   <= '0;
            tag_ins_q   <= '0;
            instr_q     <= '0;
            read_data_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_ins_q   <= tag_ins_d;
            instr_q     <= instr_d;
            read_data_q <= read_data_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_q, conflict_d;

    // Count cycles in which both requesters are active (wraps at 2^32).
    always_comb begin
        conflict_d = conflict_q;
        if (instruction_enable && data_req) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    // Conflict counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = '0;
`endif

endmodule
